// File: rtl/demux1x4.sv
// demux1x4 -- registered 1-to-4 demultiplexer.
//
// Routes data input i to one of four registered outputs selected by the
// 2-bit index {sel0, sel1} (sel0 is the MSB). Every output that is not
// selected loads RESET_VAL on the same edge, so at most one output ever
// carries routed data. Latency is exactly one clock. There is no
// combinational path from any input to any output.
//
// Ports:
//   clk        clock; all state updates on its rising edge
//   rst        synchronous active-high reset; forces every output to RESET_VAL
//   sel0       select MSB
//   sel1       select LSB
//   i          data to be routed (DATA_W bits)
//   y0..y3     registered outputs for select index 0..3 (DATA_W bits each)

// One output register. It loads i when its index is selected, and RESET_VAL
// otherwise or on reset.
module demux1x4_lane #(
  parameter int              DATA_W    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  input  logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] y
);

  always_ff @(posedge clk) begin
    if (rst)      y <= RESET_VAL;
    else if (hit) y <= i;
    else          y <= RESET_VAL;
  end

endmodule

module demux1x4 #(
  parameter int              DATA_W    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel0,
  input  logic              sel1,
  input  logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3
);

  localparam int NUM_LANES = 4;

  logic [1:0]                          idx;
  logic [NUM_LANES-1:0]                hit;
  logic [NUM_LANES-1:0][DATA_W-1:0]    yv;

  assign idx = {sel0, sel1};

  // Decoded select: exactly one lane is hit each cycle.
  always_comb begin
    hit      = '0;
    hit[idx] = 1'b1;
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux1x4_lane #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .hit (hit[g]),
      .i   (i),
      .y   (yv[g])
    );
  end

  assign y0 = yv[0];
  assign y1 = yv[1];
  assign y2 = yv[2];
  assign y3 = yv[3];

endmodule

// File: tb/tb_demux1x4.sv
module tb_demux1x4;

  localparam int DW = 4;
  localparam logic [DW-1:0] RV_B = 4'h5;

  logic clk = 1'b0;
  logic rst, sel0, sel1;
  logic [DW-1:0] i;
  logic [DW-1:0] y0, y1, y2, y3;
  logic [DW-1:0] b0, b1, b2, b3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instance with zero reset value (the value the directed vectors assume).
  demux1x4 #(.DATA_W(DW), .RESET_VAL(4'h0)) u_dut (
    .clk(clk), .rst(rst), .sel0(sel0), .sel1(sel1), .i(i),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3)
  );

  // Instance with a non-zero idle value, driven by the same inputs.
  demux1x4 #(.DATA_W(DW), .RESET_VAL(RV_B)) u_rv (
    .clk(clk), .rst(rst), .sel0(sel0), .sel1(sel1), .i(i),
    .y0(b0), .y1(b1), .y2(b2), .y3(b3)
  );

  typedef struct {
    string         name;
    logic          rst, s0, s1;
    logic [DW-1:0] i;
    logic [DW-1:0] e0, e1, e2, e3;
  } vec_t;

  vec_t tv[$];

  task automatic add(input string n, input logic r, input logic s0, input logic s1,
                     input logic [DW-1:0] di, input logic [DW-1:0] e0,
                     input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                     input logic [DW-1:0] e3);
    vec_t v;
    v.name = n; v.rst = r; v.s0 = s0; v.s1 = s1; v.i = di;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    tv.push_back(v);
  endtask

  // Drive inputs, let one rising edge sample them, look at outputs 1ns later.
  task automatic tick(input logic r, input logic s0, input logic s1, input logic [DW-1:0] di);
    rst = r; sel0 = s0; sel1 = s1; i = di;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                       input logic [DW-1:0] a2, input logic [DW-1:0] a3,
                       input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                       input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    tests++;
    if ({a3, a2, a1, a0} !== {e3, e2, e1, e0}) begin
      fails++;
      $display("FAIL %s: got y3..y0=%h %h %h %h, want %h %h %h %h",
               n, a3, a2, a1, a0, e3, e2, e1, e0);
    end
  endtask

  // Reference: the output numbered {sel0,sel1} carries i, all others idle.
  function automatic logic [DW-1:0] ref_out(input int k, input logic r, input logic s0,
                                            input logic s1, input logic [DW-1:0] di,
                                            input logic [DW-1:0] rv);
    int target;
    target = (s0 ? 2 : 0) + (s1 ? 1 : 0);
    if (r) return rv;
    return (k == target) ? di : rv;
  endfunction

  initial begin
    logic [DW-1:0] e[4];
    logic [DW-1:0] f[4];
    logic [DW-1:0] got[4];
    int busy;
    logic r, s0, s1;
    logic [DW-1:0] di;

    rst = 1'b0; sel0 = 1'b0; sel1 = 1'b0; i = '0;

    // Reset with every input set to route somewhere.
    add("reset",   1, 1, 1, 4'h1, 0, 0, 0, 0);
    // Sweep of select x data, one per cycle.
    add("sw00_i0", 0, 0, 0, 4'h0, 0, 0, 0, 0);
    add("sw00_i1", 0, 0, 0, 4'h1, 1, 0, 0, 0);
    add("sw01_i0", 0, 0, 1, 4'h0, 0, 0, 0, 0);
    add("sw01_i1", 0, 0, 1, 4'h1, 0, 1, 0, 0);
    add("sw10_i0", 0, 1, 0, 4'h0, 0, 0, 0, 0);
    add("sw10_i1", 0, 1, 0, 4'h1, 0, 0, 1, 0);
    add("sw11_i0", 0, 1, 1, 4'h0, 0, 0, 0, 0);
    add("sw11_i1", 0, 1, 1, 4'h1, 0, 0, 0, 1);
    // Select changing every cycle with data held high.
    add("tog00",   0, 0, 0, 4'h1, 1, 0, 0, 0);
    add("tog11",   0, 1, 1, 4'h1, 0, 0, 0, 1);
    add("tog01",   0, 0, 1, 4'h1, 0, 1, 0, 0);
    add("tog10",   0, 1, 0, 4'h1, 0, 0, 1, 0);
    // Mid-operation reset pulse on index 2.
    add("rp_pre",  0, 1, 0, 4'h1, 0, 0, 1, 0);
    add("rp_rst",  1, 1, 0, 4'h1, 0, 0, 0, 0);
    add("rp_post", 0, 1, 0, 4'h1, 0, 0, 1, 0);
    // Full-width word.
    add("wide_A",  0, 0, 1, 4'hA, 0, 4'hA, 0, 0);
    add("wide_F3", 0, 1, 1, 4'hF, 0, 0, 0, 4'hF);

    foreach (tv[n]) begin
      tick(tv[n].rst, tv[n].s0, tv[n].s1, tv[n].i);
      check(tv[n].name, y0, y1, y2, y3, tv[n].e0, tv[n].e1, tv[n].e2, tv[n].e3);
    end

    // Hand sequence: output must clear the cycle after the select moves away,
    // with nothing held over from the previous route.
    tick(0, 0, 0, 4'h9);
    tick(0, 0, 0, 4'h6);
    check("reload_same", y0, y1, y2, y3, 4'h6, 0, 0, 0);
    tick(0, 1, 1, 4'h0);
    check("no_stale", y0, y1, y2, y3, 0, 0, 0, 0);

    // Non-zero idle value: reset and routing of the second instance.
    tick(1, 0, 1, 4'hC);
    check("rv_reset", b0, b1, b2, b3, RV_B, RV_B, RV_B, RV_B);
    tick(0, 0, 1, 4'hC);
    check("rv_route", b0, b1, b2, b3, RV_B, 4'hC, RV_B, RV_B);

    // Randomized run against the reference, with occasional reset.
    for (int c = 0; c < 1200; c++) begin
      r  = ($urandom_range(0, 15) == 0);
      s0 = $urandom_range(0, 1);
      s1 = $urandom_range(0, 1);
      di = $urandom_range(0, 15);
      for (int k = 0; k < 4; k++) begin
        e[k] = ref_out(k, r, s0, s1, di, 4'h0);
        f[k] = ref_out(k, r, s0, s1, di, RV_B);
      end
      tick(r, s0, s1, di);
      check("rand_a", y0, y1, y2, y3, e[0], e[1], e[2], e[3]);
      check("rand_b", b0, b1, b2, b3, f[0], f[1], f[2], f[3]);
      got[0] = b0; got[1] = b1; got[2] = b2; got[3] = b3;
      busy = 0;
      for (int k = 0; k < 4; k++) if (got[k] !== RV_B) busy++;
      tests++;
      if (busy > 1) begin
        fails++;
        $display("FAIL onehot: %0d outputs away from idle value, want at most 1", busy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net in case the clock or the main sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
